pci_initiator: RTL and testbench

PCI bus initiator (master) that originates single and burst memory read/write transactions toward the PCI target buffer. Drives `frame_n`, `irdy_n`, `cbe_n` and the shared `ad` bus, and follows the target's `devsel_n`/`trdy_n` handshake. Sits between a local request interface and the PCI bus. It is the bus-stimulus source for target verification and the master-side block for system integration.

---
 rtl/pci_pkg.sv | 22 ++
 rtl/pci_ad_drive.sv | 18 +
 rtl/pci_initiator.sv | 166 ++++++++++++++++
 tb/tb_pci_initiator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared PCI definitions: bus commands, the initiator state encoding and the
// burst-length clamp used when a request is accepted.
package pci_pkg;

  localparam logic [3:0] CMD_READ  = 4'b0110;
  localparam logic [3:0] CMD_WRITE = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ABORT = 2'd3
  } pciStateT;

  // A zero length still moves one word; anything above the burst limit is cut down to it.
  function automatic logic [3:0] clampLen(input logic [3:0] len, input logic [3:0] maxLen);
    if (len == 4'd0) return 4'd1;
    if (len > maxLen) return maxLen;
    return len;
  endfunction

endpackage

// File: rtl/pci_ad_drive.sv
// Per-bit tristate driver for the shared AD bus: selects address or data and
// releases the bus when the output enable is low.
module pci_ad_drive (
  input  logic        oe,
  input  logic        selData,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  inout  wire  [31:0] ad
);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : gAdBit
      assign ad[gi] = oe ? (selData ? data[gi] : addr[gi]) : 1'bz;
    end
  endgenerate

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: turns one local request into a single or burst memory
// read/write, follows DEVSEL#/TRDY# and master-aborts an unclaimed cycle.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_BURST      = 8,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be_n,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        abort,
  output logic        frame_n,
  output logic        irdy_n,
  output logic [3:0]  cbe_n,
  inout  wire  [31:0] ad,
  input  logic        trdy_n,
  input  logic        devsel_n
);

  localparam logic [3:0]      MaxLen     = 4'(MAX_BURST);
  localparam int              CntW       = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(DEVSEL_TIMEOUT);

  pciStateT        stateReg;
  logic            isWriteReg;
  logic [31:0]     addrReg;
  logic [3:0]      remReg;
  logic [CntW-1:0] devselCntReg;
  logic            devselSeenReg;
  logic [3:0]      cbeReg;
  logic            adOeReg;
  logic            adSelDataReg;

  logic            accept;
  logic            xfer;
  logic            isLast;
  logic            devselTimeout;
  logic [CntW-1:0] devselCntNext;
  logic            writeData;

  assign accept        = req_valid && req_ready;
  assign xfer          = (stateReg == DATA) && !irdy_n && !trdy_n;
  assign isLast        = (remReg == 4'd1);
  assign devselCntNext = devselCntReg + 1'b1;
  assign devselTimeout = !devselSeenReg && devsel_n && (devselCntNext == TimeoutCnt);
  assign writeData     = (stateReg == DATA) && isWriteReg;

  // Write data and byte enables come straight from the source so a popped word is replaced without a bubble.
  assign wr_pop = xfer && isWriteReg;
  assign cbe_n  = writeData ? wr_be_n : cbeReg;

  pci_ad_drive adDrive (
    .oe      (adOeReg),
    .selData (adSelDataReg),
    .addr    (addrReg),
    .data    (wr_data),
    .ad      (ad)
  );

  // Transaction sequencer with registered bus controls and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg      <= IDLE;
      req_ready     <= 1'b1;
      frame_n       <= 1'b1;
      irdy_n        <= 1'b1;
      cbeReg        <= 4'hF;
      adOeReg       <= 1'b0;
      adSelDataReg  <= 1'b0;
      isWriteReg    <= 1'b0;
      addrReg       <= 32'h0;
      remReg        <= 4'd0;
      devselCntReg  <= '0;
      devselSeenReg <= 1'b0;
      rd_data       <= 32'h0;
      rd_valid      <= 1'b0;
      done          <= 1'b0;
      abort         <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (accept) begin
            stateReg     <= ADDR;
            req_ready    <= 1'b0;
            isWriteReg   <= req_write;
            addrReg      <= req_addr;
            remReg       <= clampLen(req_len, MaxLen);
            frame_n      <= 1'b0;
            irdy_n       <= 1'b1;
            cbeReg       <= req_write ? CMD_WRITE : CMD_READ;
            adOeReg      <= 1'b1;
            adSelDataReg <= 1'b0;
          end
        end
        ADDR: begin
          // A read releases AD here so the target gets its turnaround cycle.
          stateReg      <= DATA;
          irdy_n        <= 1'b0;
          frame_n       <= (remReg == 4'd1);
          cbeReg        <= 4'b0000;
          adOeReg       <= isWriteReg;
          adSelDataReg  <= 1'b1;
          devselCntReg  <= '0;
          devselSeenReg <= 1'b0;
        end
        DATA: begin
          if (xfer) begin
            remReg <= remReg - 4'd1;
            if (!devsel_n) devselSeenReg <= 1'b1;
            if (!isWriteReg) begin
              rd_data  <= ad;
              rd_valid <= 1'b1;
            end
            if (isLast) begin
              stateReg     <= IDLE;
              frame_n      <= 1'b1;
              irdy_n       <= 1'b1;
              cbeReg       <= 4'hF;
              adOeReg      <= 1'b0;
              adSelDataReg <= 1'b0;
              done         <= 1'b1;
              req_ready    <= 1'b1;
            end else begin
              frame_n <= (remReg == 4'd2);
            end
          end else if (devselTimeout) begin
            stateReg <= ABORT;
            frame_n  <= 1'b1;
            irdy_n   <= 1'b0;
            adOeReg  <= 1'b0;
          end else if (!devsel_n) begin
            devselSeenReg <= 1'b1;
          end else if (!devselSeenReg) begin
            devselCntReg <= devselCntNext;
          end
        end
        ABORT: begin
          stateReg     <= IDLE;
          frame_n      <= 1'b1;
          irdy_n       <= 1'b1;
          cbeReg       <= 4'hF;
          adOeReg      <= 1'b0;
          adSelDataReg <= 1'b0;
          abort        <= 1'b1;
          req_ready    <= 1'b1;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: a table of transactions run against a
// scripted target, plus hand sequences for reset and mid-burst reset.
module tb_pci_initiator;

  localparam int DevselTimeout = 5;
  localparam int NumVecs       = 8;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  len;
    int          waitPhase;
    int          waitCycles;
    logic        noDevsel;
    int          expPhases;
  } vecT;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_be_n;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        abort;
  logic        frame_n;
  logic        irdy_n;
  logic [3:0]  cbe_n;
  wire  [31:0] ad;
  logic        trdy_n;
  logic        devsel_n;

  logic        tbOe;
  logic [31:0] tbData;
  assign ad = tbOe ? tbData : 'z;

  int checks;
  int errors;

  vecT         vecs   [NumVecs];
  logic [31:0] wrWords[8];
  logic [3:0]  wrBe   [8];

  pci_initiator #(
    .MAX_BURST      (8),
    .DEVSEL_TIMEOUT (DevselTimeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_data   (wr_data),
    .wr_be_n   (wr_be_n),
    .wr_pop    (wr_pop),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .abort     (abort),
    .frame_n   (frame_n),
    .irdy_n    (irdy_n),
    .cbe_n     (cbe_n),
    .ad        (ad),
    .trdy_n    (trdy_n),
    .devsel_n  (devsel_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdWord(input int p);
    logic [7:0] b;
    b = 8'(p);
    return {16'hC0DE, b, b ^ 8'h5A};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic runTxn(input int v);
    vecT        t;
    int         phase;
    int         stallUsed;
    int         dataCycles;
    int         pops;
    logic       prevXfer;
    logic       finished;
    logic       aborted;
    logic [3:0] cmd;
    t          = vecs[v];
    cmd        = t.write ? 4'b0111 : 4'b0110;
    phase      = 0;
    stallUsed  = 0;
    dataCycles = 0;
    pops       = 0;
    prevXfer   = 1'b0;
    finished   = 1'b0;
    aborted    = 1'b0;

    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = t.write;
    req_addr  = t.addr;
    req_len   = t.len;
    @(negedge clk);
    req_valid = 1'b0;
    check("addr_frame", 32'(frame_n), 32'd0);
    check("addr_irdy", 32'(irdy_n), 32'd1);
    check("addr_cbe", 32'(cbe_n), 32'(cmd));
    check("addr_ad", ad, t.addr);
    check("addr_ready", 32'(req_ready), 32'd0);

    while (!finished && dataCycles < 40) begin
      @(negedge clk);
      if (t.noDevsel && dataCycles == DevselTimeout) begin
        check("abort_frame", 32'(frame_n), 32'd1);
        check("abort_irdy", 32'(irdy_n), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        finished = 1'b1;
        aborted  = 1'b1;
      end else begin
        dataCycles++;
        check("data_rd_valid", 32'(rd_valid), 32'(prevXfer && !t.write));
        if (prevXfer && !t.write) check("data_rd_data", rd_data, rdWord(phase - 1));
        check("data_frame", 32'(frame_n), 32'((t.expPhases - phase) == 1));
        check("data_irdy", 32'(irdy_n), 32'd0);
        if (t.noDevsel) begin
          devsel_n = 1'b1;
          trdy_n   = 1'b1;
        end else begin
          devsel_n = 1'b0;
          if (phase == t.waitPhase && stallUsed < t.waitCycles) begin
            trdy_n = 1'b1;
            stallUsed++;
          end else begin
            trdy_n = 1'b0;
          end
        end
        if (t.write) begin
          wr_data = wrWords[phase];
          wr_be_n = wrBe[phase];
        end else begin
          tbOe   = 1'b1;
          tbData = rdWord(phase);
        end
        #1;
        check("data_cbe", 32'(cbe_n), t.write ? 32'(wrBe[phase]) : 32'd0);
        check("data_ad", ad, t.write ? wrWords[phase] : rdWord(phase));
        check("data_wr_pop", 32'(wr_pop), 32'(t.write && !trdy_n));
        prevXfer = !trdy_n;
        if (!trdy_n) begin
          phase++;
          if (t.write) pops++;
          if (phase == t.expPhases) finished = 1'b1;
        end
      end
    end
    check("txn_bounded", 32'(finished), 32'd1);

    @(negedge clk);
    tbOe     = 1'b0;
    trdy_n   = 1'b1;
    devsel_n = 1'b1;
    check("end_done", 32'(done), 32'(!aborted));
    check("end_abort", 32'(abort), 32'(aborted));
    check("end_frame", 32'(frame_n), 32'd1);
    check("end_irdy", 32'(irdy_n), 32'd1);
    check("end_cbe", 32'(cbe_n), 32'hF);
    check("end_ready", 32'(req_ready), 32'd1);
    check("end_rd_valid", 32'(rd_valid), 32'(!aborted && !t.write));
    if (!aborted && !t.write) check("end_rd_data", rd_data, rdWord(t.expPhases - 1));
    check("end_phases", 32'(phase), aborted ? 32'd0 : 32'(t.expPhases));
    check("end_pops", 32'(pops), (aborted || !t.write) ? 32'd0 : 32'(t.expPhases));
    @(negedge clk);
    check("pulse_done_low", 32'(done), 32'd0);
    check("pulse_abort_low", 32'(abort), 32'd0);
    $display("txn %0d write=%0d addr=%h len=%0d phases=%0d aborted=%0d errors_so_far=%0d",
             v, t.write, t.addr, t.len, phase, aborted, errors);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_len   = 4'd0;
    wr_data   = 32'h0;
    wr_be_n   = 4'hF;
    trdy_n    = 1'b1;
    devsel_n  = 1'b1;
    tbOe      = 1'b0;
    tbData    = 32'h0;

    wrWords[0] = 32'haaaaaaaa; wrBe[0] = 4'b0101;
    wrWords[1] = 32'hbbbbbbbb; wrBe[1] = 4'b1111;
    wrWords[2] = 32'haaaacccc; wrBe[2] = 4'b0101;
    wrWords[3] = 32'hdddddddd; wrBe[3] = 4'b1100;
    wrWords[4] = 32'h11112222; wrBe[4] = 4'b0000;
    wrWords[5] = 32'h33334444; wrBe[5] = 4'b1010;
    wrWords[6] = 32'h55556666; wrBe[6] = 4'b0011;
    wrWords[7] = 32'h77778888; wrBe[7] = 4'b1110;

    //          write addr          len    wPh wCyc noDev  phases
    vecs[0] = '{1'b1, 32'h00001000, 4'd4,  -1, 0, 1'b0, 4};
    vecs[1] = '{1'b0, 32'h00001000, 4'd8,   2, 2, 1'b0, 8};
    vecs[2] = '{1'b1, 32'h00002000, 4'd1,  -1, 0, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h00003000, 4'd0,  -1, 0, 1'b0, 1};
    vecs[4] = '{1'b1, 32'h00004000, 4'd15, -1, 0, 1'b0, 8};
    vecs[5] = '{1'b0, 32'h00005000, 4'd2,  -1, 0, 1'b1, 2};
    vecs[6] = '{1'b1, 32'h00006000, 4'd4,  -1, 0, 1'b1, 4};
    vecs[7] = '{1'b0, 32'h00007000, 4'd3,   0, 3, 1'b0, 3};

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check("rst_frame", 32'(frame_n), 32'd1);
    check("rst_irdy", 32'(irdy_n), 32'd1);
    check("rst_cbe", 32'(cbe_n), 32'hF);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_pop", 32'(wr_pop), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NumVecs; i++) runTxn(i);

    // Reset during the second data phase of a 4-phase write.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h00008000;
    req_len   = 4'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    devsel_n = 1'b0;
    trdy_n   = 1'b0;
    wr_data  = wrWords[0];
    wr_be_n  = wrBe[0];
    @(negedge clk);
    check("mid_phase2_irdy", 32'(irdy_n), 32'd0);
    trdy_n  = 1'b1;
    wr_data = wrWords[1];
    wr_be_n = wrBe[1];
    rst     = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    tbOe   = 1'b1;
    tbData = 32'h5a5a5a5a;
    #1;
    check("mid_rst_frame", 32'(frame_n), 32'd1);
    check("mid_rst_irdy", 32'(irdy_n), 32'd1);
    check("mid_rst_cbe", 32'(cbe_n), 32'hF);
    check("mid_rst_ad_released", ad, 32'h5a5a5a5a);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_wr_pop", 32'(wr_pop), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    tbOe     = 1'b0;
    devsel_n = 1'b1;
    check("mid_rst_no_done", 32'(done), 32'd0);
    check("mid_rst_no_abort", 32'(abort), 32'd0);
    $display("txn reset-mid-burst write addr=00008000 len=4 errors_so_far=%0d", errors);

    runTxn(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
